gcd_lcm_unit: RTL and testbench
===============================

Name: gcd_lcm_unit

Overview:
- Parametrised, handshaked successor to the team's fixed 32-bit LCM FSM.
- Computes GCD or LCM of two unsigned WIDTH-bit operands.
  - GCD uses binary (Stein) iteration.
  - LCM is (a / gcd) * b, using a sequential restoring divider and a shift-add multiplier.
- Sits as a multi-cycle arithmetic coprocessor behind a start/done handshake. The full 2*WIDTH-bit LCM is returned with no overflow.

Parameters:
- WIDTH, 32, operand width in bits (legal 4..64).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = GCD, 1 = LCM; captured with start
- a  in  WIDTH  operand A; captured with start
- b  in  WIDTH  operand B; captured with start
- busy  out  1  high from cycle after accepted start until the cycle done is asserted
- done  out  1  one-cycle pulse; result valid from this cycle on
- result  out  2*WIDTH  GCD zero-extended, or LCM; held until next done

Behaviour:
- Reset (rst=1 at posedge): state to IDLE, busy=0, done=0, result=0. Reset mid-operation aborts the operation with no done pulse; internal registers are don't-care.
- FSM states: IDLE, ZCHK, GCD_SHIFT, GCD_LOOP, DIV, MUL, FINISH.
- IDLE:
  - start=1 latches a, b, mode, then goes to ZCHK; busy=1 next cycle.
  - start=0 stays in IDLE.
  - start while busy is ignored and has no side effects.
- ZCHK, zero rules:
  - a=0 or b=0: GCD result = a|b (gcd(0,0)=0); LCM result = 0. Go straight to FINISH.
  - Otherwise go to GCD_SHIFT.
- GCD_SHIFT: while both x and y are even, shift both right by 1 and increment k. Then go to GCD_LOOP.
- GCD_LOOP, one action per cycle:
  - x even: x>>=1.
  - else y even: y>>=1.
  - else x>=y: x=(x-y)>>1.
  - else: y=(y-x)>>1.
  - Exit when x==0 or y==0: g = (x|y) << k.
  - mode=0 goes to FINISH with result=g; mode=1 goes to DIV.
- DIV: restoring division q = a_lat / g, exactly WIDTH cycles, one quotient bit per cycle MSB first. The remainder is always 0 (no check required).
- MUL: shift-add q * b_lat into a 2*WIDTH accumulator, exactly WIDTH cycles, LSB first. Then FINISH.
- FINISH:
  - result register loads the final value.
  - done=1 and busy=0 for this one cycle.
  - Next state IDLE.
  - start is not accepted in FINISH; the earliest new accept is the cycle after.
- Latency:
  - Start-accept edge to done pulse ≤ 2 cycles for zero operands.
  - ≤ 3*WIDTH+3 cycles for GCD.
  - ≤ 5*WIDTH+3 cycles for LCM.
  - The bench checks against these bounds, not exact counts.
- Arithmetic:
  - All unsigned.
  - Internal x, y are WIDTH bits; k is clog2(WIDTH)+1 bits.
  - The LCM accumulator never overflows 2*WIDTH.
- Operand inputs may change freely after the accept cycle.
- result holds its value across IDLE and across aborted (reset) operations only until rst clears it.

Test Plan:
- WIDTH=32, mode=1, a=12, b=18 -> one done pulse, result=36, busy high in between, latency ≤ 163.
- mode=0, a=48, b=180 -> result=12. Then a=17, b=5 -> result=1. Then a=b=0xFFFFFFFF -> result=0xFFFFFFFF.
- mode=1, a=0xFFFFFFFF, b=0xFFFFFFFE -> result=0xFFFFFFFD_00000002 (full 64-bit, coprime operands).
- Zero operands:
  - mode=0, a=0, b=7 -> 7.
  - mode=0, a=0, b=0 -> 0.
  - mode=1, a=5, b=0 -> 0.
  - Each with done within 2 cycles of accept.
- Handshake:
  - Pulse start again mid-operation with different operands -> ignored; the original result is returned.
  - Assert start in the FINISH cycle -> not accepted.
  - Assert start the cycle after FINISH -> accepted.
- Assert rst mid-LCM -> busy=0, done=0, result=0 next cycle, no done pulse. A new start then computes lcm(4,6)=12 correctly.

Source files
------------

// File: rtl/gcd_lcm_if.sv
// Start/done handshake bundle for the GCD/LCM coprocessor.
// The master issues operands; the slave returns a busy flag, a done pulse and the result.
interface gcd_lcm_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (output start, mode, a, b, input busy, done, result);
  modport slave  (input start, mode, a, b, output busy, done, result);
endinterface

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD (binary Stein) / LCM ((a/gcd)*b) coprocessor.
// Uses a restoring divider and a shift-add multiplier, so the full 2*WIDTH LCM is returned.
module gcd_lcm_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  gcd_lcm_if.slave   bus
);
  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE, ZCHK, GCD_SHIFT, GCD_LOOP, DIV, MUL, FINISH
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, g_q, g_d;
  logic [KW-1:0]        k_q, k_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     g_calc;
  logic [WIDTH:0]       trial, diff;
  logic                 qbit;
  logic [2*WIDTH-1:0]   acc_sum;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    g_d      = g_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    g_calc  = (x_q | y_q) << k_q;
    // Restoring divider: shift the next dividend bit into the partial remainder.
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, g_q};
    qbit    = (trial >= {1'b0, g_q});
    acc_sum = acc_q + (quo_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          x_d     = bus.a;
          y_d     = bus.b;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ZCHK;
        end
      end
      ZCHK: begin
        if (a_q == '0 || b_q == '0) begin
          result_d = mode_q ? '0 : {{WIDTH{1'b0}}, a_q | b_q};
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = FINISH;
        end else begin
          state_d = GCD_SHIFT;
        end
      end
      GCD_SHIFT: begin
        if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + 1'b1;
        end else begin
          state_d = GCD_LOOP;
        end
      end
      GCD_LOOP: begin
        if (x_q == '0 || y_q == '0) begin
          g_d = g_calc;
          if (mode_q) begin
            quo_d   = a_q;
            rem_d   = '0;
            cnt_d   = KW'(WIDTH - 1);
            state_d = DIV;
          end else begin
            result_d = {{WIDTH{1'b0}}, g_calc};
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = FINISH;
          end
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q >= y_q) begin
          x_d = (x_q - y_q) >> 1;
        end else begin
          y_d = (y_q - x_q) >> 1;
        end
      end
      DIV: begin
        rem_d = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], qbit};
        if (cnt_q == '0) begin
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, b_q};
          cnt_d   = KW'(WIDTH - 1);
          state_d = MUL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MUL: begin
        acc_d   = acc_sum;
        quo_d   = quo_q >> 1;
        mcand_d = mcand_q << 1;
        if (cnt_q == '0) begin
          result_d = acc_sum;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      g_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      g_q      <= g_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed vectors, handshake/reset sequences
// and random operations against a Euclid-based reference model.
module tb_gcd_lcm_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_lcm_if #(.WIDTH(W)) bus();

  gcd_lcm_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [2*W-1:0] ref_result(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] g;
    g = ref_gcd(a, b);
    if (!mode) return {{W{1'b0}}, g};
    if (a == 0 || b == 0) return '0;
    return (2*W)'(a / g) * (2*W)'(b);
  endfunction

  function automatic int bound_for(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 0 || b == 0) return 2;
    return mode ? 5*W + 3 : 3*W + 3;
  endfunction

  task automatic issue(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the first falling edge after the accept edge; returns at the done cycle.
  task automatic wait_done(input string name, input int bound, input logic [2*W-1:0] exp, input int glitch_at);
    int lat;
    bit busy_ok;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < bound + 8) begin
      if (!bus.busy) busy_ok = 1'b0;
      bus.start = (lat == glitch_at);
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.mode  = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({name, " done_seen"}, 64'(bus.done), 64'd1);
    check({name, " latency_ok"}, 64'(lat <= bound), 64'd1);
    check({name, " busy_during"}, 64'(busy_ok), 64'd1);
    check({name, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({name, " result"}, bus.result, exp);
  endtask

  task automatic run_op(input string name, input logic mode, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int glitch_at);
    logic [2*W-1:0] exp;
    exp = ref_result(mode, a, b);
    issue(mode, a, b);
    wait_done(name, bound_for(mode, a, b), exp, glitch_at);
    @(negedge clk);
    check({name, " done_pulse"}, 64'(bus.done), 64'd0);
    check({name, " result_held"}, bus.result, exp);
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] ra, rb;
    logic rm;

    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{1'b1, 32'd12,         32'd18,         64'd36};
    vecs[1] = '{1'b0, 32'd48,         32'd180,        64'd12};
    vecs[2] = '{1'b0, 32'd17,         32'd5,          64'd1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  64'hFFFF_FFFD_0000_0002};
    vecs[5] = '{1'b0, 32'd0,          32'd7,          64'd7};
    vecs[6] = '{1'b0, 32'd0,          32'd0,          64'd0};
    vecs[7] = '{1'b1, 32'd5,          32'd0,          64'd0};
    vecs[8] = '{1'b1, 32'd4,          32'd6,          64'd12};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", bus.result, 64'd0);

    for (int i = 0; i < 9; i++) begin
      logic [2*W-1:0] exp;
      exp = vecs[i].exp;
      issue(vecs[i].mode, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), bound_for(vecs[i].mode, vecs[i].a, vecs[i].b), exp, -1);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), 64'(bus.done), 64'd0);
      $display("vec%0d mode=%0d a=%h b=%h result=%h", i, vecs[i].mode, vecs[i].a, vecs[i].b, bus.result);
    end

    // A start pulse while busy must not disturb the running operation.
    run_op("glitch_lcm", 1'b1, 32'd12, 32'd18, 5);
    run_op("glitch_gcd", 1'b0, 32'd1000, 32'd250, 3);
    $display("glitch sequences result=%h", bus.result);

    // Start held through the FINISH cycle: rejected there, accepted one cycle later.
    issue(1'b0, 32'd48, 32'd180);
    wait_done("fin_first", 3*W + 3, 64'd12, -1);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.a     = 32'd17;
    bus.b     = 32'd5;
    @(negedge clk);
    check("fin_start rejected busy", 64'(bus.busy), 64'd0);
    check("fin_start rejected result", bus.result, 64'd12);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("fin_after", 3*W + 3, 64'd1, -1);
    @(negedge clk);
    $display("finish-cycle start sequence result=%h", bus.result);

    // Reset mid-LCM aborts without a done pulse.
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort result", bus.result, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort no_done", 64'(done_cnt), 64'd0);
    run_op("post_abort", 1'b1, 32'd4, 32'd6, -1);
    $display("reset-abort sequence result=%h", bus.result);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
        1: begin ra = ra << $urandom_range(0, 8); rb = rb << $urandom_range(0, 8); end
        2: if ($urandom_range(0, 3) == 0) ra = '0;
        default: ;
      endcase
      rm = 1'($urandom);
      run_op($sformatf("rnd%0d", i), rm, ra, rb, -1);
      $display("rnd%0d mode=%0d a=%h b=%h result=%h", i, rm, ra, rb, bus.result);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
